// File: rtl/RS5_pkg.sv
// rtl/RS5_pkg.sv - shared encodings for the AES word unit
package RS5_pkg;

    typedef enum logic [1:0] {
        OP_SUBWORD = 2'b00,
        OP_ROTSUB  = 2'b01,
        OP_ESI     = 2'b10,
        OP_ESMI    = 2'b11
    } aes_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SUB  = 2'b01,
        ST_MIX  = 2'b10,
        ST_DONE = 2'b11
    } aes_state_e;

endpackage

// File: rtl/riscv_crypto_aes_fwd_sbox.sv
// rtl/riscv_crypto_aes_fwd_sbox.sv - combinational AES forward S-box
module riscv_crypto_aes_fwd_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] fx
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse as a^254 = a^2 * a^4 * ... * a^128; this also maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    logic [7:0] inv;

    assign inv = gf_inv(in_byte);
    assign fx  = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;

endmodule

// File: rtl/aes_word_unit.sv
// rtl/aes_word_unit.sv - multi-cycle AES SubWord/RotSub/ESI/ESMI unit on one shared S-box
module aes_word_unit
    import RS5_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    input  logic [1:0]  bs_i,
    output logic        busy_o,
    output logic        valid_o,
    output logic [31:0] result_o
);

    aes_state_e  state;
    aes_state_e  state_next;
    aes_op_e     op_q;
    logic [31:0] rs1_q;
    logic [31:0] rs2_q;
    logic [1:0]  bs_q;
    logic [1:0]  cnt;
    logic [7:0]  y_q;
    logic [31:0] sub_q;
    logic [31:0] result_q;

    logic        accept;
    logic [31:0] word_src;
    logic [7:0]  sbox_in;
    logic [7:0]  sbox_out;
    logic [31:0] sub_next;
    logic [31:0] esi_res;
    logic [31:0] mix;
    logic [63:0] mix_dbl;
    logic [31:0] esmi_res;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    assign accept   = start_i && (state == ST_IDLE || state == ST_DONE);
    assign word_src = (op_q == OP_ROTSUB) ? {rs1_q[7:0], rs1_q[31:8]} : rs1_q;

    always_comb begin
        sbox_in = 8'h00;
        if (op_q == OP_SUBWORD || op_q == OP_ROTSUB)
            sbox_in = word_src[{cnt, 3'b000} +: 8];
        else
            sbox_in = rs2_q[{bs_q, 3'b000} +: 8];
    end

    riscv_crypto_aes_fwd_sbox u_sbox (
        .in_byte (sbox_in),
        .fx      (sbox_out)
    );

    // The last SubWord byte lands in the same edge that loads the result.
    always_comb begin
        sub_next = sub_q;
        sub_next[{cnt, 3'b000} +: 8] = sbox_out;
    end

    assign esi_res  = rs1_q ^ ({24'h000000, sbox_out} << {bs_q, 3'b000});
    assign mix      = {xtime(y_q) ^ y_q, y_q, y_q, xtime(y_q)};
    assign mix_dbl  = {mix, mix} << {bs_q, 3'b000};
    assign esmi_res = rs1_q ^ mix_dbl[63:32];

    always_ff @(posedge clk) begin
        if (!reset_n)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start_i) state_next = ST_SUB;
            ST_SUB: begin
                case (op_q)
                    OP_ESI:  state_next = ST_DONE;
                    OP_ESMI: state_next = ST_MIX;
                    default: if (cnt == 2'd3) state_next = ST_DONE;
                endcase
            end
            ST_MIX:  state_next = ST_DONE;
            ST_DONE: state_next = start_i ? ST_SUB : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o  = 1'b0;
        valid_o = 1'b0;
        case (state)
            ST_SUB, ST_MIX: busy_o  = 1'b1;
            ST_DONE:        valid_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            op_q     <= OP_SUBWORD;
            rs1_q    <= 32'h0;
            rs2_q    <= 32'h0;
            bs_q     <= 2'd0;
            cnt      <= 2'd0;
            y_q      <= 8'h00;
            sub_q    <= 32'h0;
            result_q <= 32'h0;
        end else begin
            if (accept) begin
                op_q  <= aes_op_e'(op_i);
                rs1_q <= rs1_i;
                rs2_q <= rs2_i;
                bs_q  <= bs_i;
                cnt   <= 2'd0;
            end else if (state == ST_SUB) begin
                cnt   <= cnt + 2'd1;
                y_q   <= sbox_out;
                sub_q <= sub_next;
                if (state_next == ST_DONE)
                    result_q <= (op_q == OP_ESI) ? esi_res : sub_next;
            end else if (state == ST_MIX) begin
                result_q <= esmi_res;
            end
        end
    end

    assign result_o = result_q;

endmodule

// File: tb/tb_aes_word_unit.sv
// tb/tb_aes_word_unit.sv - randomized self-checking bench for aes_word_unit
module tb_aes_word_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_i = 1'b0;
    logic [1:0]  op_i = 2'd0;
    logic [31:0] rs1_i = 32'h0;
    logic [31:0] rs2_i = 32'h0;
    logic [1:0]  bs_i = 2'd0;
    logic        busy_o;
    logic        valid_o;
    logic [31:0] result_o;

    int total = 0;
    int bad = 0;
    logic [7:0] sb [256];

    always #5 clk = ~clk;

    aes_word_unit dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start_i  (start_i),
        .op_i     (op_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .bs_i     (bs_i),
        .busy_o   (busy_o),
        .valid_o  (valid_o),
        .result_o (result_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Polynomial product, then reduction modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--)
            if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] cst;
        cst = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int c = 1; c < 256; c++)
                if (gmul(8'(x), 8'(c)) == 8'h01) inv = 8'(c);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8]
                     ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ cst[i];
            sb[x] = s;
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [1:0] s);
        logic [31:0] w;
        logic [31:0] r;
        logic [31:0] m;
        logic [7:0]  y;
        int sh;
        sh = 8 * int'(s);
        r = 32'h0;
        y = sb[b[sh +: 8]];
        case (op)
            2'd0, 2'd1: begin
                w = (op == 2'd1) ? {a[7:0], a[31:8]} : a;
                for (int k = 0; k < 4; k++) r[8*k +: 8] = sb[w[8*k +: 8]];
            end
            2'd2: r = a ^ ({24'h0, y} << sh);
            default: begin
                m = {gmul(y, 8'h03), y, y, gmul(y, 8'h02)};
                r = a ^ ((m << sh) | (m >> (32 - sh)));
            end
        endcase
        return r;
    endfunction

    function automatic int lat_of(input logic [1:0] op);
        return (op == 2'd2) ? 2 : (op == 2'd3) ? 3 : 5;
    endfunction

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] s);
        @(negedge clk);
        op_i = op; rs1_i = a; rs2_i = b; bs_i = s; start_i = 1'b1;
    endtask

    // Entered just before the accept edge with start_i already high.
    task automatic wait_result(input int exp_lat, input logic [31:0] exp_res, input bit glitch,
                               input bit chain, input logic [1:0] nop, input logic [31:0] na,
                               input logic [31:0] nb, input logic [1:0] ns);
        int n;
        int busy_cnt;
        @(negedge clk);
        start_i = 1'b0;
        op_i = 2'($urandom); rs1_i = $urandom; rs2_i = $urandom; bs_i = 2'($urandom);
        n = 1;
        busy_cnt = 0;
        while (!valid_o && n < 20) begin
            if (busy_o) busy_cnt++;
            start_i = (glitch && busy_o) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            n++;
        end
        if (chain) begin
            op_i = nop; rs1_i = na; rs2_i = nb; bs_i = ns; start_i = 1'b1;
        end else begin
            start_i = 1'b0;
        end
        check_eq("latency", n, exp_lat);
        check_eq("busy_cycles", busy_cnt, exp_lat - 1);
        check_eq("valid", 32'(valid_o), 32'd1);
        check_eq("result", result_o, exp_res);
        if (!chain) begin
            @(negedge clk);
            check_eq("valid_width", 32'(valid_o), 32'd0);
            check_eq("idle_after", 32'(busy_o), 32'd0);
        end
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  s;
        int vcnt;

        build_sbox();

        reset_n = 1'b0; start_i = 1'b1; op_i = 2'd2;
        repeat (3) @(negedge clk);
        check_eq("reset_busy", 32'(busy_o), 32'd0);
        check_eq("reset_valid", 32'(valid_o), 32'd0);
        check_eq("reset_result", result_o, 32'h0);
        reset_n = 1'b1; start_i = 1'b0;
        @(negedge clk);
        check_eq("start_on_reset_dropped", 32'(busy_o), 32'd0);

        issue(2'd0, 32'h03020100, 32'h0, 2'd0);
        wait_result(5, 32'h7B777C63, 1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 2'd0);
        issue(2'd1, 32'h03020100, 32'h0, 2'd0);
        wait_result(5, 32'h637B777C, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 2'd0);
        issue(2'd2, 32'h0, 32'h00005300, 2'd1);
        wait_result(2, 32'h0000ED00, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 2'd0);
        issue(2'd2, 32'hFFFFFFFF, 32'h00005300, 2'd1);
        wait_result(2, 32'hFFFF12FF, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 2'd0);
        issue(2'd3, 32'h0, 32'h00000001, 2'd0);
        wait_result(3, 32'h847C7CF8, 1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 2'd0);
        issue(2'd3, 32'h0, 32'h00000100, 2'd1);
        wait_result(3, 32'h7C7CF884, 1'b0, 1'b1, 2'd2, 32'hFFFFFFFF, 32'h00005300, 2'd1);
        wait_result(2, 32'hFFFF12FF, 1'b0, 1'b1, 2'd0, 32'h03020100, 32'h0, 2'd0);
        wait_result(5, 32'h7B777C63, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 2'd0);

        for (int it = 0; it < 40; it++) begin
            op = 2'($urandom); a = $urandom; b = $urandom; s = 2'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(op, a, b, s);
            if (it % 5 == 4) begin
                logic [1:0]  op2;
                logic [31:0] a2;
                logic [31:0] b2;
                logic [1:0]  s2;
                op2 = 2'($urandom); a2 = $urandom; b2 = $urandom; s2 = 2'($urandom);
                wait_result(lat_of(op), model(op, a, b, s), 1'b1, 1'b1, op2, a2, b2, s2);
                wait_result(lat_of(op2), model(op2, a2, b2, s2), 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 2'd0);
            end else begin
                wait_result(lat_of(op), model(op, a, b, s), 1'($urandom_range(0, 1)), 1'b0,
                            2'd0, 32'h0, 32'h0, 2'd0);
            end
        end

        issue(2'd0, 32'h03020100, 32'h0, 2'd0);
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        check_eq("abort_busy_before", 32'(busy_o), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        check_eq("abort_busy", 32'(busy_o), 32'd0);
        check_eq("abort_valid", 32'(valid_o), 32'd0);
        check_eq("abort_result", result_o, 32'h0);
        reset_n = 1'b1;
        vcnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (valid_o) vcnt++;
        end
        check_eq("abort_no_valid", vcnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
